// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with standard (1-cycle read latency) or first-word-fall-through read port.
// Writes are rejected when full unless a read is accepted in the same cycle; reads are rejected when empty. Both set sticky errors.
module sync_fifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wa, ra;
  logic [31:0]      count_ext;

  assign count_ext    = 32'(count_q);
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_ext >= 32'(AF_LEVEL));
  assign almost_empty = (count_ext <= 32'(AE_LEVEL));

  // A read frees a slot in the same cycle, so a write at full still goes in.
  assign ra = rd_en && !empty;
  assign wa = wr_en && (!full || ra);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = ra;
    if (wa) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ra) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wa, ra})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error in the clearing cycle must survive the clear.
    ovf_d = (ovf_q && !err_clr) || (wr_en && !wa);
    udf_d = (udf_q && !err_clr) || (rd_en && !ra);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wa) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : rd_data_q;
  assign rd_valid  = (FWFT != 0) ? !empty : rd_valid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard-mode and a FWFT instance share stimulus and are checked against a queue model.
module tb_sync_fifo_flex;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, wr_en, rd_en, err_clr;
  logic [W-1:0] wr_data;

  logic [W-1:0] s_rd_data, f_rd_data;
  logic         s_rd_valid, f_rd_valid, s_full, f_full, s_empty, f_empty;
  logic         s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
  logic [2:0]   s_count, f_count;

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf), .err_clr(err_clr));

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .err_clr(err_clr));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of stored words plus the sticky flags and the standard-mode read register.
  byte unsigned q[$];
  bit           m_ovf, m_udf, m_rv;
  logic [W-1:0] m_rdd;

  typedef struct {
    bit           r, w;
    logic [W-1:0] d;
    bit           rd, ec;
    int           cnt;
    bit           full, empty, af, ae, ovf, udf;
    logic [W-1:0] rdd;
    bit           rv;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit w, input logic [W-1:0] d, input bit rd, input bit ec);
    bit ra, wa;
    if (r) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rdd = '0; m_rv = 0;
    end else begin
      ra = rd && (q.size() > 0);
      wa = w && ((q.size() < D) || ra);
      m_rv = ra;
      if (ra) m_rdd = q.pop_front();
      if (wa) q.push_back(d);
      m_ovf = (m_ovf && !ec) || (w && !wa);
      m_udf = (m_udf && !ec) || (rd && !ra);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("mdl.s_count", 32'(s_count), n);
    chk("mdl.f_count", 32'(f_count), n);
    chk("mdl.s_full",  32'(s_full),  32'(n == D));
    chk("mdl.f_full",  32'(f_full),  32'(n == D));
    chk("mdl.s_empty", 32'(s_empty), 32'(n == 0));
    chk("mdl.f_empty", 32'(f_empty), 32'(n == 0));
    chk("mdl.s_af",    32'(s_af),    32'(n >= 3));
    chk("mdl.s_ae",    32'(s_ae),    32'(n <= 1));
    chk("mdl.f_af",    32'(f_af),    32'(n >= 3));
    chk("mdl.f_ae",    32'(f_ae),    32'(n <= 1));
    chk("mdl.s_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("mdl.s_udf",   32'(s_udf),   32'(m_udf));
    chk("mdl.f_ovf",   32'(f_ovf),   32'(m_ovf));
    chk("mdl.f_udf",   32'(f_udf),   32'(m_udf));
    chk("mdl.s_rd_data",  32'(s_rd_data),  32'(m_rdd));
    chk("mdl.s_rd_valid", 32'(s_rd_valid), 32'(m_rv));
    chk("mdl.f_rd_valid", 32'(f_rd_valid), 32'(n > 0));
    if (n > 0) chk("mdl.f_rd_data", 32'(f_rd_data), 32'(q[0]));
  endtask

  task automatic step(input bit r, input bit w, input logic [W-1:0] d, input bit rd, input bit ec);
    rst = r; wr_en = w; wr_data = d; rd_en = rd; err_clr = ec;
    @(posedge clk);
    model_update(r, w, d, rd, ec);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;
    m_ovf = 0; m_udf = 0; m_rv = 0; m_rdd = '0;

    //             r w  d     rd ec cnt fu em af ae ov ud rdd   rv
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 1, 8'h11, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00, 0};
    tbl[2]  = '{0, 1, 8'h22, 0, 0, 2, 0, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[3]  = '{0, 1, 8'h33, 0, 0, 3, 0, 0, 1, 0, 0, 0, 8'h00, 0};
    tbl[4]  = '{0, 1, 8'h44, 0, 0, 4, 1, 0, 1, 0, 0, 0, 8'h00, 0};
    tbl[5]  = '{0, 1, 8'h55, 0, 0, 4, 1, 0, 1, 0, 1, 0, 8'h00, 0};
    tbl[6]  = '{0, 0, 8'h00, 0, 1, 4, 1, 0, 1, 0, 0, 0, 8'h00, 0};
    tbl[7]  = '{0, 1, 8'h66, 1, 0, 4, 1, 0, 1, 0, 0, 0, 8'h11, 1};
    tbl[8]  = '{0, 0, 8'h00, 1, 0, 3, 0, 0, 1, 0, 0, 0, 8'h22, 1};
    tbl[9]  = '{0, 0, 8'h00, 1, 0, 2, 0, 0, 0, 0, 0, 0, 8'h33, 1};
    tbl[10] = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 8'h44, 1};
    tbl[11] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 0, 8'h66, 1};
    tbl[12] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 1, 8'h66, 0};
    tbl[13] = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 1, 8'h66, 0};
    tbl[14] = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 0, 1, 8'h66, 0};
    tbl[15] = '{0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 8'h66, 0};
    tbl[16] = '{0, 1, 8'h77, 1, 0, 1, 0, 0, 0, 1, 0, 1, 8'h66, 0};
    tbl[17] = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 0, 0, 8'h77, 1};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rd, tbl[i].ec);
      chk($sformatf("vec%0d.count", i),    32'(s_count),    tbl[i].cnt);
      chk($sformatf("vec%0d.full", i),     32'(s_full),     32'(tbl[i].full));
      chk($sformatf("vec%0d.empty", i),    32'(s_empty),    32'(tbl[i].empty));
      chk($sformatf("vec%0d.af", i),       32'(s_af),       32'(tbl[i].af));
      chk($sformatf("vec%0d.ae", i),       32'(s_ae),       32'(tbl[i].ae));
      chk($sformatf("vec%0d.ovf", i),      32'(s_ovf),      32'(tbl[i].ovf));
      chk($sformatf("vec%0d.udf", i),      32'(s_udf),      32'(tbl[i].udf));
      chk($sformatf("vec%0d.rd_data", i),  32'(s_rd_data),  32'(tbl[i].rdd));
      chk($sformatf("vec%0d.rd_valid", i), 32'(s_rd_valid), 32'(tbl[i].rv));
    end

    // Write/read pairs walk both pointers past the wrap point.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'(i), 0, 0);
      chk("wrap.count_wr", 32'(s_count), 1);
      chk("wrap.fwft_head", 32'(f_rd_data), i);
      step(0, 0, 8'h00, 1, 0);
      chk("wrap.count_rd", 32'(s_count), 0);
      chk("wrap.rd_data", 32'(s_rd_data), i);
      chk("wrap.rd_valid", 32'(s_rd_valid), 1);
    end

    step(0, 1, 8'hA5, 0, 0);
    chk("fwft.rd_data", 32'(f_rd_data), 32'h0A5);
    chk("fwft.rd_valid", 32'(f_rd_valid), 1);
    step(0, 0, 8'h00, 1, 0);
    chk("fwft.empty", 32'(f_empty), 1);
    chk("fwft.rd_valid_pop", 32'(f_rd_valid), 0);

    for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("rstclr.pre_count", 32'(s_count), 3);
    chk("rstclr.pre_ovf", 32'(s_ovf), 1);
    step(1, 1, 8'hEE, 1, 0);
    chk("rstclr.count", 32'(s_count), 0);
    chk("rstclr.empty", 32'(s_empty), 1);
    chk("rstclr.ovf", 32'(s_ovf), 0);
    chk("rstclr.f_rd_valid", 32'(f_rd_valid), 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i + 8'h30), 0, 0);
    step(0, 1, 8'hEE, 0, 1);
    chk("rstclr.set_wins", 32'(s_ovf), 1);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(99) < 60), 8'($urandom),
           ($urandom_range(99) < 50), ($urandom_range(15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
